// File: rtl/sv_ptw.sv
`default_nettype none
// ============================================================================
//  Module   : sv_ptw
//  Brief    : Sequential Sv39/Sv48 page-table walker with a single-port
//             PTE read channel, bare mode, superpages and fault reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module sv_ptw #(
    parameter int LEVELS    = 3,
    parameter int SATP_MODE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ptw_i_req_valid,
    output logic        ptw_o_req_ready,
    input  logic [63:0] ptw_i_vaddr,
    input  logic [63:0] ptw_i_satp,
    input  logic [1:0]  ptw_i_acc,
    output logic        ptw_o_mem_valid,
    input  logic        ptw_i_mem_ready,
    output logic [63:0] ptw_o_mem_addr,
    input  logic        ptw_i_mem_rvalid,
    input  logic [63:0] ptw_i_mem_rdata,
    output logic        ptw_o_resp_valid,
    output logic [63:0] ptw_o_paddr,
    output logic        ptw_o_fault
);

    localparam int c_va_bits = 12 + 9 * LEVELS;
    localparam int c_lvl_w   = $clog2(LEVELS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_REQ  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [63:0]          r_vaddr, w_vaddr_nxt;
    logic [1:0]           r_acc, w_acc_nxt;
    logic [c_lvl_w-1:0]   r_lvl, w_lvl_nxt;
    logic [55:0]          r_base, w_base_nxt;
    logic [63:0]          r_paddr, w_paddr_nxt;
    logic                 r_fault, w_fault_nxt;

    // Request-side decode (only meaningful in IDLE)
    logic [3:0]  w_mode;
    logic        w_canonical;

    assign w_mode      = ptw_i_satp[63:60];
    assign w_canonical = (&ptw_i_vaddr[63:c_va_bits-1]) | ~(|ptw_i_vaddr[63:c_va_bits-1]);

    // Level-dependent address arithmetic
    logic [5:0]  w_lvl_sh;
    logic [8:0]  w_vpn;
    logic [55:0] w_pte_addr;
    logic [55:0] w_off_mask;
    logic [43:0] w_ppn_mask;

    assign w_lvl_sh   = 6'(r_lvl) * 6'd9;
    assign w_vpn      = r_vaddr[(6'd12 + w_lvl_sh) +: 9];
    assign w_pte_addr = r_base + {44'b0, w_vpn, 3'b000};
    assign w_off_mask = (56'd1 << (w_lvl_sh + 6'd12)) - 56'd1;
    assign w_ppn_mask = (44'd1 << w_lvl_sh) - 44'd1;

    // PTE decode
    logic [43:0] w_ppn;
    logic        w_pte_v, w_pte_r, w_pte_w, w_pte_x, w_pte_a, w_pte_d;
    logic        w_is_store, w_is_fetch;
    logic        w_perm_ok, w_misaligned;
    logic [55:0] w_leaf_pa;

    assign w_ppn        = ptw_i_mem_rdata[53:10];
    assign w_pte_v      = ptw_i_mem_rdata[0];
    assign w_pte_r      = ptw_i_mem_rdata[1];
    assign w_pte_w      = ptw_i_mem_rdata[2];
    assign w_pte_x      = ptw_i_mem_rdata[3];
    assign w_pte_a      = ptw_i_mem_rdata[6];
    assign w_pte_d      = ptw_i_mem_rdata[7];
    assign w_is_store   = (r_acc == 2'b01);
    assign w_is_fetch   = (r_acc == 2'b10);
    assign w_perm_ok    = w_is_fetch ? w_pte_x :
                          w_is_store ? (w_pte_r & w_pte_w) : w_pte_r;
    assign w_misaligned = |(w_ppn & w_ppn_mask);
    // Superpage: upper PPN bits from the PTE, remaining offset from the VA
    assign w_leaf_pa    = ({w_ppn, 12'b0} & ~w_off_mask) | (r_vaddr[55:0] & w_off_mask);

    logic w_unused;
    assign w_unused = ^{ptw_i_satp[59:44], ptw_i_mem_rdata[63:54],
                        ptw_i_mem_rdata[5:4], r_vaddr[63:56]};

    always_comb begin
        w_state_nxt = r_state;
        w_vaddr_nxt = r_vaddr;
        w_acc_nxt   = r_acc;
        w_lvl_nxt   = r_lvl;
        w_base_nxt  = r_base;
        w_paddr_nxt = r_paddr;
        w_fault_nxt = r_fault;
        case (r_state)
            S_IDLE: begin
                if (ptw_i_req_valid) begin
                    w_vaddr_nxt = ptw_i_vaddr;
                    w_acc_nxt   = ptw_i_acc;
                    w_lvl_nxt   = c_lvl_w'(LEVELS - 1);
                    w_base_nxt  = {ptw_i_satp[43:0], 12'b0};
                    w_paddr_nxt = 64'b0;
                    w_fault_nxt = 1'b0;
                    if (w_mode == 4'd0) begin
                        w_paddr_nxt = {8'b0, ptw_i_vaddr[55:0]};
                        w_state_nxt = S_RESP;
                    end else if ((w_mode != 4'(SATP_MODE)) || !w_canonical) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_MEM_REQ;
                    end
                end
            end
            S_MEM_REQ: begin
                if (ptw_i_mem_ready) begin
                    w_state_nxt = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (ptw_i_mem_rvalid) begin
                    w_state_nxt = S_RESP;
                    w_paddr_nxt = 64'b0;
                    w_fault_nxt = 1'b1;
                    if (!w_pte_v || (!w_pte_r && w_pte_w)) begin
                        w_fault_nxt = 1'b1;
                    end else if (w_pte_r || w_pte_x) begin
                        if (w_perm_ok && w_pte_a && !(w_is_store && !w_pte_d) && !w_misaligned) begin
                            w_fault_nxt = 1'b0;
                            w_paddr_nxt = {8'b0, w_leaf_pa};
                        end
                    end else if (r_lvl != '0) begin
                        w_fault_nxt = 1'b0;
                        w_base_nxt  = {w_ppn, 12'b0};
                        w_lvl_nxt   = r_lvl - c_lvl_w'(1);
                        w_state_nxt = S_MEM_REQ;
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vaddr <= 64'b0;
            r_acc   <= 2'b0;
            r_lvl   <= '0;
            r_base  <= 56'b0;
            r_paddr <= 64'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vaddr <= w_vaddr_nxt;
            r_acc   <= w_acc_nxt;
            r_lvl   <= w_lvl_nxt;
            r_base  <= w_base_nxt;
            r_paddr <= w_paddr_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign ptw_o_req_ready  = (r_state == S_IDLE);
    assign ptw_o_mem_valid  = (r_state == S_MEM_REQ);
    assign ptw_o_mem_addr   = (r_state == S_MEM_REQ) ? {8'b0, w_pte_addr} : 64'b0;
    assign ptw_o_resp_valid = (r_state == S_RESP);
    assign ptw_o_paddr      = r_paddr;
    assign ptw_o_fault      = r_fault;

endmodule
`default_nettype wire

// File: doc/sv_ptw.md
Name: sv_ptw

Overview:
- Sequential hardware page-table walker that translates a 64-bit virtual address under satp.
- Parametrised for Sv39 (3 levels) or Sv48 (4 levels).
- Sits between the core's fetch/LSU translation requests and a single-port memory read channel.
- Supports bare mode, superpages, permission and A/D checks, and page-fault reporting.

Parameters:
LEVELS, 3, page-table levels: 3 for Sv39, 4 for Sv48; VA_BITS = 12 + 9*LEVELS
SATP_MODE, 8, satp.MODE value enabling translation (8 for Sv39, 9 for Sv48)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ptw_i_req_valid  input  1  translation request valid
ptw_o_req_ready  output  1  walker idle, request accepted when valid&ready
ptw_i_vaddr  input  64  virtual address
ptw_i_satp  input  64  satp: MODE[63:60], ASID[59:44], PPN[43:0]
ptw_i_acc  input  2  access type: 00 load, 01 store, 10 fetch (11 treated as load)
ptw_o_mem_valid  output  1  PTE read request valid
ptw_i_mem_ready  input  1  memory accepts request
ptw_o_mem_addr  output  64  PTE physical address, 8-byte aligned
ptw_i_mem_rvalid  input  1  PTE data valid
ptw_i_mem_rdata  input  64  PTE data
ptw_o_resp_valid  output  1  one-cycle result pulse
ptw_o_paddr  output  64  physical address, zero-extended from 56 bits
ptw_o_fault  output  1  page fault; paddr is 0 when set

Behaviour:
- Reset values: req_ready=1, mem_valid=0, mem_addr=0, resp_valid=0, paddr=0, fault=0, state=IDLE.
- Reset mid-walk: return to IDLE and drop the walk. A mem_rvalid arriving in IDLE is ignored.
- States: IDLE, MEM_REQ, MEM_WAIT, RESP.
- IDLE: on valid&ready, latch vaddr, satp and acc; lvl = LEVELS-1; base = satp.PPN<<12. Then:
  - MODE==0 (bare): paddr = vaddr, fault = 0, go to RESP.
  - MODE not in {0, SATP_MODE}: fault, go to RESP.
  - Non-canonical vaddr (bits [63:VA_BITS] not all equal to bit VA_BITS-1): fault, no memory access, go to RESP.
  - Otherwise go to MEM_REQ.
- MEM_REQ:
  - mem_valid=1; mem_addr = base + vpn[lvl]*8, where vpn[i] = vaddr[12+9i+8:12+9i].
  - mem_addr and mem_valid stay stable until ready. Go to MEM_WAIT on mem_valid&mem_ready.
- MEM_WAIT: wait for mem_rvalid. rvalid in the same cycle as the handshake is not allowed; earliest is the next cycle. Decode the PTE:
  - V=0, or (R=0 and W=1): fault.
  - Leaf (R|X):
    - Permission: load needs R; store needs R&W; fetch needs X; else fault.
    - A=0 or (store & D=0): fault. No hardware A/D update.
    - Superpage misalignment: lvl>0 and PPN[9*lvl-1:0] != 0: fault.
    - Else paddr = {8'b0, PPN[43:9*lvl], vaddr[12+9*lvl-1:0]}.
  - Pointer:
    - lvl==0: fault.
    - Else base = PPN<<12, lvl--, back to MEM_REQ.
  - PPN = rdata[53:10]. Bits 63:54 are ignored.
- RESP:
  - resp_valid=1 for exactly one cycle, paddr/fault valid in that cycle. Consumer must sample it.
  - Return to IDLE; req_ready=1 the following cycle.
- req_ready=1 only in IDLE. Requests are not queued.
- Latency:
  - Bare mode or early fault: request at cycle N, resp_valid at N+1.
  - Full Sv39 walk with zero-wait memory (ready=1, rvalid 1 cycle after handshake): resp at N+1+2*3.
- Inputs are not sampled outside IDLE. satp changes mid-walk have no effect on the current walk.
- Arithmetic: base is 56 bits; adds wrap modulo 2^56; mem_addr is zero-extended to 64.

Test Plan:
1. Bare: satp=0, vaddr=0x0000_0000_8000_1234 -> resp_valid at N+1, paddr=0x8000_1234, fault=0, mem_valid never asserted.
2. Sv39 4KiB walk:
   - Setup: satp=0x8000_0000_0008_0000; vaddr=0x0000_0000_4020_3ABC.
   - Expected PTE addresses: L2 0x8000_0008, L1 0x8100_0008, L0 0x8200_0018.
   - PTEs: L2 0x2040_0001 (pointer), L1 0x2080_0001 (pointer), L0 0x2400_00CF (leaf RWXAD, PPN 0x90000).
   - Load -> paddr=0x9000_0ABC, fault=0, resp at N+7 with zero-wait memory.
3. 1GiB superpage: L2 PTE 0x2000_00CF (PPN 0x80000), vaddr=0x4012_3456 -> paddr=0x8012_3456. Same PTE with PPN 0x80001 -> fault (misaligned).
4. Permission/A/D faults:
   - Leaf 0x2400_0043 (R,A,no W) with store -> fault.
   - Leaf 0x2400_004B (RX,A) with fetch -> paddr ok.
   - Leaf 0x2400_0003 (A=0) with load -> fault.
5. Invalid/canonical:
   - vaddr=0x0000_0080_0000_0000 in Sv39 -> fault at N+1, no memory request.
   - L1 PTE V=0 -> fault after 2 memory reads.
   - Pointer PTE at level 0 -> fault.
6. Backpressure and reset:
   - Hold mem_ready=0 for 5 cycles -> mem_addr stable throughout.
   - Assert rst in MEM_WAIT, then deliver rvalid -> no resp_valid, req_ready=1 after reset, next request translates correctly.
